// File: rtl/hazard3_regfile_wport_seq.sv
// Write-port sequencer for a non-reset (BRAM-style) 1W2R register file.
// After reset, or when init_req is seen, it sweeps addresses 0..N_REGS-1 and
// writes INIT_VALUE to each one. Otherwise it forwards core writebacks to the
// regfile write port through one register stage.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active high
//   init_req     request a full clear (pulse or level)
//   core_waddr   core writeback address
//   core_wdata   core writeback data
//   core_wen     core writeback valid, held until accepted
//   core_wready  core write accepted when core_wen && core_wready (== idle)
//   rf_waddr     regfile write address (registered)
//   rf_wdata     regfile write data (registered)
//   rf_wen       regfile write enable (registered)
//   init_busy    clear sweep in progress
//   init_done    one-cycle pulse alongside the final clear write on rf_*
module hazard3_regfile_wport_seq #(
  parameter int unsigned        N_REGS     = 16,
  parameter int unsigned        W_DATA     = 32,
  parameter int unsigned        W_ADDR     = 5,
  parameter logic [W_DATA-1:0]  INIT_VALUE = '0,
  parameter int unsigned        DROP_X0    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic [W_ADDR-1:0] core_waddr,
  input  logic [W_DATA-1:0] core_wdata,
  input  logic              core_wen,
  output logic              core_wready,
  output logic [W_ADDR-1:0] rf_waddr,
  output logic [W_DATA-1:0] rf_wdata,
  output logic              rf_wen,
  output logic              init_busy,
  output logic              init_done
);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  // One bit wider than the address so N_REGS == 2**W_ADDR cannot wrap.
  localparam logic [W_ADDR:0] CNT_LAST = (W_ADDR + 1)'(N_REGS - 1);

  state_t            state;
  logic [W_ADDR:0]   cnt;
  logic              core_to_x0;

  assign core_to_x0  = (DROP_X0 != 0) && (core_waddr == '0);
  assign core_wready = (state == S_IDLE);
  assign init_busy   = (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      cnt       <= '0;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          rf_wen   <= 1'b1;
          rf_waddr <= cnt[W_ADDR-1:0];
          rf_wdata <= INIT_VALUE;
          // A restart request takes priority over finishing the sweep, so
          // init_done only fires at the end of an uninterrupted pass.
          if (init_req) begin
            cnt       <= '0;
            init_done <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            cnt       <= cnt + 1'b1;
            state     <= S_IDLE;
            init_done <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            init_done <= 1'b0;
          end
        end
        S_IDLE: begin
          rf_wen    <= core_wen && !core_to_x0;
          init_done <= 1'b0;
          if (core_wen) begin
            rf_waddr <= core_waddr;
            rf_wdata <= core_wdata;
          end
          // A core write in the same cycle is still issued; the sweep then
          // overwrites it.
          if (init_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard3_regfile_wport_seq.sv
module tb_hazard3_regfile_wport_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        core_wen;

  logic        core_wready, rf_wen, init_busy, init_done;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        a_core_wready, a_rf_wen, a_init_busy, a_init_done;
  logic [4:0]  a_rf_waddr;
  logic [31:0] a_rf_wdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  hazard3_regfile_wport_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .init_req    (init_req),
    .core_waddr  (core_waddr),
    .core_wdata  (core_wdata),
    .core_wen    (core_wen),
    .core_wready (core_wready),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wen      (rf_wen),
    .init_busy   (init_busy),
    .init_done   (init_done)
  );

  // Same stimulus, x0 writes allowed and all-ones clear value.
  hazard3_regfile_wport_seq #(
    .N_REGS     (16),
    .W_DATA     (32),
    .W_ADDR     (5),
    .INIT_VALUE (32'hffffffff),
    .DROP_X0    (0)
  ) u_alt (
    .clk         (clk),
    .rst         (rst),
    .init_req    (init_req),
    .core_waddr  (core_waddr),
    .core_wdata  (core_wdata),
    .core_wen    (core_wen),
    .core_wready (a_core_wready),
    .rf_waddr    (a_rf_waddr),
    .rf_wdata    (a_rf_wdata),
    .rf_wen      (a_rf_wen),
    .init_busy   (a_init_busy),
    .init_done   (a_init_done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_wen",   32'(rf_wen), 32'd0);
    chk("rst_busy",  32'(init_busy), 32'd1);
    chk("rst_ready", 32'(core_wready), 32'd0);
    chk("rst_done",  32'(init_done), 32'd0);
    chk("rst_addr",  32'(rf_waddr), 32'd0);
    rst = 1'b0;
  endtask

  // Checks clear writes to addresses first..first+n-1; init_done expected on
  // the last one only when done_at_end is set.
  task automatic run_sweep(input int first, input int n, input bit done_at_end);
    for (int i = first; i < first + n; i++) begin
      bit last;
      last = done_at_end && (i == first + n - 1);
      tick();
      chk("sw_wen",   32'(rf_wen), 32'd1);
      chk("sw_addr",  32'(rf_waddr), 32'(i));
      chk("sw_data",  rf_wdata, 32'd0);
      chk("sw_done",  32'(init_done), 32'(last));
      chk("sw_busy",  32'(init_busy), 32'(!last));
      chk("sw_ready", 32'(core_wready), 32'(last));
      chk("alt_addr", 32'(a_rf_waddr), 32'(i));
      chk("alt_data", a_rf_wdata, 32'hffffffff);
    end
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b0; core_wen = 1'b0;
    core_waddr = '0; core_wdata = '0;

    // Power-on clear
    do_reset();
    run_sweep(0, 16, 1'b1);
    tick();
    chk("idle_wen",  32'(rf_wen), 32'd0);
    chk("idle_done", 32'(init_done), 32'd0);

    // Single core write, one-cycle latency, no repeat
    core_wen = 1'b1; core_waddr = 5'd5; core_wdata = 32'hdeadbeef;
    tick();
    core_wen = 1'b0;
    chk("w5_wen",  32'(rf_wen), 32'd1);
    chk("w5_addr", 32'(rf_waddr), 32'd5);
    chk("w5_data", rf_wdata, 32'hdeadbeef);
    tick();
    chk("w5_norep", 32'(rf_wen), 32'd0);

    // x0 write: dropped by default instance, passed by alt instance
    core_wen = 1'b1; core_waddr = 5'd0; core_wdata = 32'h1234;
    tick();
    core_wen = 1'b0;
    chk("x0_drop",     32'(rf_wen), 32'd0);
    chk("x0_pass_wen", 32'(a_rf_wen), 32'd1);
    chk("x0_pass_adr", 32'(a_rf_waddr), 32'd0);
    chk("x0_pass_dat", a_rf_wdata, 32'h1234);

    // Core write held through reset clear
    core_wen = 1'b1; core_waddr = 5'd7; core_wdata = 32'h00000077;
    do_reset();
    run_sweep(0, 16, 1'b1);
    tick();
    core_wen = 1'b0;
    chk("held_wen",  32'(rf_wen), 32'd1);
    chk("held_addr", 32'(rf_waddr), 32'd7);
    chk("held_data", rf_wdata, 32'h00000077);
    tick();
    chk("held_norep", 32'(rf_wen), 32'd0);

    // init_req in IDLE together with a core write
    core_wen = 1'b1; core_waddr = 5'd3; core_wdata = 32'h00000abc;
    init_req = 1'b1;
    tick();
    core_wen = 1'b0; init_req = 1'b0;
    chk("ir_wen",   32'(rf_wen), 32'd1);
    chk("ir_addr",  32'(rf_waddr), 32'd3);
    chk("ir_data",  rf_wdata, 32'h00000abc);
    chk("ir_busy",  32'(init_busy), 32'd1);
    chk("ir_ready", 32'(core_wready), 32'd0);
    run_sweep(0, 16, 1'b1);

    // Restart at cnt==9
    do_reset();
    run_sweep(0, 9, 1'b0);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("r9_addr", 32'(rf_waddr), 32'd9);
    chk("r9_done", 32'(init_done), 32'd0);
    run_sweep(0, 16, 1'b1);

    // Restart at the final clear edge: no done pulse
    do_reset();
    run_sweep(0, 15, 1'b0);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("r15_addr", 32'(rf_waddr), 32'd15);
    chk("r15_done", 32'(init_done), 32'd0);
    chk("r15_busy", 32'(init_busy), 32'd1);
    run_sweep(0, 16, 1'b1);

    // Reset mid-clear at cnt==4
    do_reset();
    run_sweep(0, 4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_wen",     32'(rf_wen), 32'd0);
    chk("mr_alt_wen", 32'(a_rf_wen), 32'd0);
    chk("mr_busy",    32'(init_busy), 32'd1);
    run_sweep(0, 16, 1'b1);
    chk("mr_alt_done", 32'(a_init_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
